// File: rtl/spi_cmd_decoder.sv
// Decodes SPI packets into parameter-memory accesses; READ responds with load at N+2+READ_LATENCY.
// No backpressure: packets arriving outside IDLE are dropped and flagged on sticky overrun.
module spi_cmd_decoder #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 10,
  parameter int READ_LATENCY = 2,
  localparam int PACKET_WIDTH = DATA_WIDTH + 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [PACKET_WIDTH-1:0] rxData,
  input  logic                    dataReady,
  output logic [PACKET_WIDTH-1:0] txData,
  output logic                    load,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic                    mem_we,
  output logic                    mem_re,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    overrun
);

  localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ_REQ,
    S_READ_WAIT,
    S_RESPOND
  } state_t;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_SET   = 2'b11;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  autoinc;
  logic [CNT_W-1:0]      cnt;
  logic [1:0]            op;

  // Reserved header bits carry no meaning.
  logic unused_hdr;
  assign unused_hdr = ^rxData[PACKET_WIDTH-4:PACKET_WIDTH-8];

  assign op       = rxData[PACKET_WIDTH-1:PACKET_WIDTH-2];
  assign mem_addr = addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      addr      <= '0;
      autoinc   <= 1'b0;
      cnt       <= '0;
      txData    <= '0;
      load      <= 1'b0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      mem_wdata <= '0;
      overrun   <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      mem_re <= 1'b0;
      load   <= 1'b0;
      if (dataReady && state != S_IDLE) overrun <= 1'b1;
      case (state)
        S_IDLE: begin
          if (dataReady) begin
            autoinc <= rxData[PACKET_WIDTH-3];
            case (op)
              OP_NOP: if (rxData[0]) overrun <= 1'b0;
              OP_WRITE: begin
                mem_we    <= 1'b1;
                mem_wdata <= rxData[DATA_WIDTH-1:0];
                state     <= S_WRITE;
              end
              OP_READ: begin
                mem_re <= 1'b1;
                state  <= S_READ_REQ;
              end
              OP_SET: addr <= rxData[ADDR_WIDTH-1:0];
              default: ;
            endcase
          end
        end
        S_WRITE: begin
          if (autoinc) addr <= addr + ADDR_WIDTH'(1);
          state <= S_IDLE;
        end
        S_READ_REQ: begin
          if (autoinc) addr <= addr + ADDR_WIDTH'(1);
          cnt   <= CNT_W'(READ_LATENCY - 1);
          state <= S_READ_WAIT;
        end
        S_READ_WAIT: begin
          // Last wait cycle is the one where mem_rdata becomes valid.
          if (cnt == '0) begin
            txData <= {4'hA, 3'b000, overrun, mem_rdata};
            load   <= 1'b1;
            state  <= S_RESPOND;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_RESPOND: state <= S_IDLE;
        default:   state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Drives three decoders (READ_LATENCY 2, 1, 4) with shared packets against a latency-accurate memory model.
module tb_spi_cmd_decoder;

  typedef struct {
    logic [39:0] pkt;
    logic [9:0]  exp_ptr;
    logic [39:0] exp_tx;
    logic        exp_ovr;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [39:0] rxData = '0;
  logic        dataReady = 1'b0;

  logic [31:0] mem [1024];
  int cyc = 0;
  int dr_edge = 0;
  int passed = 0;
  int total = 0;
  logic [9:0] model_ptr = '0;

  logic [39:0] tx_a [3];
  logic [9:0]  addr_a [3];
  logic [9:0]  are_a [3];
  logic        ovr_a [3];
  int nload_a [3], cload_a [3], nwe_a [3], cwe_a [3], nre_a [3], cre_a [3];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (dataReady) dr_edge <= cyc + 1;
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g
    localparam int RL = (gi == 0) ? 2 : ((gi == 1) ? 1 : 4);
    logic [39:0] txData;
    logic        load, mem_we, mem_re, overrun;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic [31:0] pipe [RL];
    int n_load = 0, c_load = 0, n_we = 0, c_we = 0, n_re = 0, c_re = 0;
    logic [9:0] a_re = '0;

    spi_cmd_decoder #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .READ_LATENCY(RL)) dut (
      .clk(clk), .rst(rst), .rxData(rxData), .dataReady(dataReady),
      .txData(txData), .load(load), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata), .overrun(overrun)
    );

    // Read data is valid RL cycles after the cycle mem_re is high.
    always @(posedge clk) begin
      pipe[0] <= mem_re ? mem[mem_addr] : 32'h0;
      for (int k = 1; k < RL; k++) pipe[k] <= pipe[k-1];
    end
    assign mem_rdata = pipe[RL-1];

    always @(negedge clk) begin
      if (load)   begin n_load <= n_load + 1; c_load <= cyc; end
      if (mem_we) begin n_we <= n_we + 1; c_we <= cyc; end
      if (mem_re) begin n_re <= n_re + 1; c_re <= cyc; a_re <= mem_addr; end
    end

    assign tx_a[gi]    = txData;
    assign addr_a[gi]  = mem_addr;
    assign are_a[gi]   = a_re;
    assign ovr_a[gi]   = overrun;
    assign nload_a[gi] = n_load;
    assign cload_a[gi] = c_load;
    assign nwe_a[gi]   = n_we;
    assign cwe_a[gi]   = c_we;
    assign nre_a[gi]   = n_re;
    assign cre_a[gi]   = c_re;
  end

  always @(posedge clk) begin
    if (g[0].mem_we) mem[g[0].mem_addr] <= g[0].mem_wdata;
  end

  function automatic int rl_of(input int i);
    return (i == 0) ? 2 : ((i == 1) ? 1 : 4);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  task automatic send(input logic [39:0] pkt);
    @(negedge clk);
    rxData    = pkt;
    dataReady = 1'b1;
    @(negedge clk);
    dataReady = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    int l0 [3];
    int we0, re0;
    logic [1:0] op;
    logic [9:0] p0;
    op  = v.pkt[39:38];
    p0  = model_ptr;
    for (int i = 0; i < 3; i++) l0[i] = nload_a[i];
    we0 = nwe_a[0];
    re0 = nre_a[0];
    send(v.pkt);
    repeat (12) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("ptr rl=%0d pkt=%h", rl_of(i), v.pkt), 64'(addr_a[i]), 64'(v.exp_ptr));
      chk($sformatf("overrun rl=%0d pkt=%h", rl_of(i), v.pkt), 64'(ovr_a[i]), 64'(v.exp_ovr));
      if (op == 2'b10) begin
        chk($sformatf("load count rl=%0d pkt=%h", rl_of(i), v.pkt), 64'(nload_a[i] - l0[i]), 64'd1);
        chk($sformatf("load cycle rl=%0d", rl_of(i)), 64'(cload_a[i] - dr_edge + 1), 64'(2 + rl_of(i)));
        chk($sformatf("txData rl=%0d pkt=%h", rl_of(i), v.pkt), 64'(tx_a[i]), 64'(v.exp_tx));
      end else begin
        chk($sformatf("no load rl=%0d pkt=%h", rl_of(i), v.pkt), 64'(nload_a[i] - l0[i]), 64'd0);
      end
    end
    if (op == 2'b10) begin
      chk("mem_re count", 64'(nre_a[0] - re0), 64'd1);
      chk("mem_re cycle", 64'(cre_a[0] - dr_edge + 1), 64'd1);
      chk("mem_re addr", 64'(are_a[0]), 64'(p0));
    end
    if (op == 2'b01) begin
      chk("mem_we count", 64'(nwe_a[0] - we0), 64'd1);
      chk("mem_we cycle", 64'(cwe_a[0] - dr_edge + 1), 64'd1);
      chk($sformatf("mem[%h]", p0), 64'(mem[p0]), 64'(v.pkt[31:0]));
    end
    model_ptr = v.exp_ptr;
  endtask

  vec_t tbl [14];
  int l0 [3];

  initial begin
    tbl[0]  = '{40'hC0_00000005, 10'h005, 40'h0, 1'b0};
    tbl[1]  = '{40'h60_11111111, 10'h006, 40'h0, 1'b0};
    tbl[2]  = '{40'h60_22222222, 10'h007, 40'h0, 1'b0};
    tbl[3]  = '{40'hC0_00000005, 10'h005, 40'h0, 1'b0};
    tbl[4]  = '{40'hA0_00000000, 10'h006, 40'hA0_11111111, 1'b0};
    tbl[5]  = '{40'h80_00000000, 10'h006, 40'hA0_22222222, 1'b0};
    tbl[6]  = '{40'hC0_000003FF, 10'h3FF, 40'h0, 1'b0};
    tbl[7]  = '{40'h60_DEADBEEF, 10'h000, 40'h0, 1'b0};
    tbl[8]  = '{40'hC0_000003FF, 10'h3FF, 40'h0, 1'b0};
    tbl[9]  = '{40'hA0_00000000, 10'h000, 40'hA0_DEADBEEF, 1'b0};
    tbl[10] = '{40'hE0_FFFFFC05, 10'h005, 40'h0, 1'b0};
    tbl[11] = '{40'h00_00000000, 10'h005, 40'h0, 1'b0};
    tbl[12] = '{40'h40_12345678, 10'h005, 40'h0, 1'b0};
    tbl[13] = '{40'hBF_00000000, 10'h006, 40'hA0_12345678, 1'b0};
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;

    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset txData rl=%0d", rl_of(i)), 64'(tx_a[i]), 64'h0);
      chk($sformatf("reset ptr rl=%0d", rl_of(i)), 64'(addr_a[i]), 64'h0);
      chk($sformatf("reset overrun rl=%0d", rl_of(i)), 64'(ovr_a[i]), 64'h0);
    end
    chk("reset load", 64'(g[0].load), 64'h0);
    chk("reset mem_we", 64'(g[0].mem_we), 64'h0);
    chk("reset mem_re", 64'(g[0].mem_re), 64'h0);
    chk("reset mem_wdata", 64'(g[0].mem_wdata), 64'h0);

    for (int i = 0; i < 14; i++) apply(tbl[i]);

    // Packet two cycles after a READ is dropped and raises overrun.
    apply('{40'hC0_00000005, 10'h005, 40'h0, 1'b0});
    send(40'h80_00000000);
    send(40'h40_BAD0BAD0);
    repeat (12) @(negedge clk);
    for (int i = 0; i < 3; i++)
      chk($sformatf("overrun set rl=%0d", rl_of(i)), 64'(ovr_a[i]), 64'h1);
    chk("dropped write mem[5]", 64'(mem[5]), 64'h12345678);
    chk("dropped ptr", 64'(addr_a[0]), 64'h005);
    apply('{40'h00_00000000, 10'h005, 40'h0, 1'b1});
    apply('{40'h80_00000000, 10'h005, 40'hA1_12345678, 1'b1});
    apply('{40'h00_00000001, 10'h005, 40'h0, 1'b0});

    // Reset while every instance sits in READ_WAIT.
    apply('{40'hC0_00000009, 10'h009, 40'h0, 1'b0});
    for (int i = 0; i < 3; i++) l0[i] = nload_a[i];
    send(40'hA0_00000000);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst mid-read load rl=%0d", rl_of(i)), 64'(nload_a[i] - l0[i]), 64'h0);
      chk($sformatf("rst mid-read txData rl=%0d", rl_of(i)), 64'(tx_a[i]), 64'h0);
      chk($sformatf("rst mid-read ptr rl=%0d", rl_of(i)), 64'(addr_a[i]), 64'h0);
    end
    model_ptr = 10'h000;
    apply('{40'hC0_00000006, 10'h006, 40'h0, 1'b0});
    apply('{40'hA0_00000000, 10'h007, 40'hA0_22222222, 1'b0});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
